score_counter: RTL
==================

# score_counter

Game-score accumulator for the Snake design: counts food-eaten events during play and presents the running score as two packed BCD digits to the seven-segment score display. It sits between the snake game-logic FSM (source of `I_eat`, `I_game_over`, `I_start`) and the score display block, whose 8-bit BCD score input it drives directly. It also holds the session best score.

## Interface
- `POINTS`, default 1: BCD points added per food event; legal range 1..9.
- `I_clk`  input  1  system clock, 100 MHz.
- `I_rst`  input  1  synchronous, active-high reset.
- `I_start`  input  1  level; starts or restarts a game.
- `I_eat`  input  1  level from game logic; each rising edge is one food event.
- `I_game_over`  input  1  level; snake collision.
- `O_score`  output  8  running score, packed BCD: [7:4] tens, [3:0] ones; feeds the display's score input.
- `O_best`  output  8  best score this power-on, packed BCD.
- `O_playing`  output  1  high while in PLAY.
- `O_new_best`  output  1  one-cycle pulse when `O_best` is updated.

## Operation
- Reset values: all outputs 0, FSM = IDLE, edge register = 0.
- The FSM has three states:
  - IDLE: score held at 0. Moves to PLAY when `I_start` is high.
  - PLAY: counts food events. Moves to OVER when `I_game_over` is high.
  - OVER: score frozen. Moves to PLAY when `I_start` is high, and `O_score` clears to 0 on that same edge.
- Edge detect: `eat_q` registers `I_eat` every cycle, in every state. A food event is `I_eat & ~eat_q`. A level held high across a state change does not retrigger.
- Food events are counted only in PLAY and only when `I_game_over` is low. An event that coincides with `I_game_over` is dropped.
- BCD add, performed per event:
  - `ones + POINTS`; if the result is > 9, subtract 10 and carry 1 into tens.
  - `tens + carry`; if the result is > 9, the score saturates at 8'h99.
  - The score never wraps.
- Best-score update on the PLAY→OVER edge:
  - If `O_score > O_best`, `O_best <= O_score` and `O_new_best` pulses for 1 cycle.
  - Unsigned compare of the raw packed byte is valid for legal BCD.
  - Equal scores produce no update and no pulse.
- `I_start` in PLAY is ignored. `I_game_over` in IDLE or OVER is ignored.
- `I_rst` mid-game returns the block to reset values on the next edge, including `O_best`.
- Invalid `POINTS` (0 or >9) is a parameter error.

## Timing
- Food-event latency: `I_eat` is first sampled high at edge N, and `O_score` shows the new value after edge N.
- Back-to-back events need at least one low cycle on `I_eat` between them. The maximum counting rate is one event per 2 cycles.
- `O_playing` is registered and changes on the same edge as the state.
- `O_new_best` is high for exactly the cycle after the PLAY→OVER edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro `SCORE_BEST_EN`.
- Defined: best-score register, compare logic, and `O_new_best` are built as described in Operation.
- Undefined: the best-score logic is removed. `O_best` is tied to 8'h00 and `O_new_best` is tied to 0. Every other behaviour is unchanged.

## Structure
- A shared package, `snake_pkg`, holds:
  - FSM state encoding: IDLE=2'd0, PLAY=2'd1, OVER=2'd2.
  - `BCD_MAX = 8'h99`.
  - `BCD_DIGIT_MAX = 4'd9`.
- Sub-module `bcd_add_sat` is combinational:
  - Inputs: 8-bit packed BCD and a 4-bit addend.
  - Output: the saturated 8-bit packed BCD sum.
  - It is verified standalone by an exhaustive sweep of 100 scores × 9 addends.

## Test plan
- Reset → `O_score=00`, `O_best=00`, `O_playing=0`. Then pulse `I_start` → `O_playing=1` one edge later.
- `POINTS=1`, PLAY, 12 single-cycle `I_eat` pulses → `O_score=8'h12`. Check the ones-digit carry at the 9→10 event.
- `POINTS=7`, start at score 8'h95, one event → 8'h99 (saturation). A further event keeps 8'h99.
- `I_eat` held high for 20 cycles → exactly one increment.
- `I_eat` rising edge in the same cycle as `I_game_over` → score unchanged, state OVER.
- Game 1 ends at 8'h23 → `O_best=8'h23` with a `O_new_best` pulse. Game 2 ends at 8'h23 → no pulse. Game 3 ends at 8'h40 → `O_best=8'h40` with a pulse. Repeat without `SCORE_BEST_EN` → `O_best` stays 8'h00 and no pulses occur.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the Snake score path: FSM encoding, BCD limits and
// the legal-range rule for the per-food points value.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [7:0] BCD_MAX       = 8'h99;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic bit points_ok(input int unsigned p);
    return (p >= 1) && (p <= 9);
  endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational packed-BCD adder: adds a single-digit addend to a two-digit
// score and clamps at 99 instead of wrapping.
module bcd_add_sat
  import snake_pkg::*;
(
  input  logic [7:0] i_score,
  input  logic [3:0] i_addend,
  output logic [7:0] o_sum
);

  logic [4:0] w_ones_raw;
  logic [3:0] w_ones;
  logic       w_carry;
  logic [4:0] w_tens;

  always_comb begin
    w_ones_raw = {1'b0, i_score[3:0]} + {1'b0, i_addend};
    w_carry    = (w_ones_raw > {1'b0, BCD_DIGIT_MAX});
    w_ones     = w_carry ? 4'(w_ones_raw - 5'd10) : w_ones_raw[3:0];
    w_tens     = {1'b0, i_score[7:4]} + {4'd0, w_carry};
    // A tens overflow means the true sum is 100 or more.
    if (w_tens > {1'b0, BCD_DIGIT_MAX}) begin
      o_sum = BCD_MAX;
    end else begin
      o_sum = {w_tens[3:0], w_ones};
    end
  end

endmodule

// File: rtl/score_counter.sv
// Snake score accumulator: counts rising edges of I_eat while playing and
// keeps a session best score when built with SCORE_BEST_EN defined.
module score_counter
  import snake_pkg::*;
#(
  parameter int unsigned POINTS = 1
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_start,
  input  logic       I_eat,
  input  logic       I_game_over,
  output logic [7:0] O_score,
  output logic [7:0] O_best,
  output logic       O_playing,
  output logic       O_new_best,
  output state_t     O_state
);

  if (!points_ok(POINTS)) begin : g_bad_points
    $error("score_counter: POINTS must be in 1..9");
  end

  localparam logic [3:0] ADDEND = 4'(POINTS);

  // Inputs are plain levels with no handshake: a food event is the cycle in
  // which I_eat is high after being low, and it is consumed on that edge.
  state_t     r_state;
  state_t     w_state_next;
  logic       r_eat_q;
  logic       w_event;
  logic [7:0] r_score;
  logic [7:0] w_score_next;
  logic [7:0] w_sum;
  logic       r_playing;

  assign w_event = I_eat & ~r_eat_q;

  bcd_add_sat u_add (
    .i_score  (r_score),
    .i_addend (ADDEND),
    .o_sum    (w_sum)
  );

  always_comb begin
    w_state_next = r_state;
    w_score_next = r_score;
    case (r_state)
      ST_IDLE: begin
        w_score_next = '0;
        if (I_start) w_state_next = ST_PLAY;
      end
      ST_PLAY: begin
        // Game over wins over a coincident food event.
        if (I_game_over) begin
          w_state_next = ST_OVER;
        end else if (w_event) begin
          w_score_next = w_sum;
        end
      end
      ST_OVER: begin
        if (I_start) begin
          w_state_next = ST_PLAY;
          w_score_next = '0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_score_next = '0;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state   <= ST_IDLE;
      r_eat_q   <= 1'b0;
      r_score   <= '0;
      r_playing <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_eat_q   <= I_eat;
      r_score   <= w_score_next;
      r_playing <= (w_state_next == ST_PLAY);
    end
  end

  assign O_score   = r_score;
  assign O_playing = r_playing;
  assign O_state   = r_state;

`ifdef SCORE_BEST_EN
  logic [7:0] r_best;
  logic       r_new_best;
  logic       w_end_game;

  // Packed BCD compares correctly as an unsigned byte.
  assign w_end_game = (r_state == ST_PLAY) && I_game_over;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_best     <= '0;
      r_new_best <= 1'b0;
    end else begin
      r_new_best <= 1'b0;
      if (w_end_game && (r_score > r_best)) begin
        r_best     <= r_score;
        r_new_best <= 1'b1;
      end
    end
  end

  assign O_best     = r_best;
  assign O_new_best = r_new_best;
`else
  assign O_best     = 8'h00;
  assign O_new_best = 1'b0;
`endif

endmodule
